input_buffer_first: RTL and testbench
=====================================

INPUT_BUFFER_FIRST -- requirements
Module: input_buffer_first

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, gives the number of storage entries and SHALL equal 2**FIFO_WIDTH.
REQ-002 Parameter FIFO_WIDTH, default 4, gives the pointer/address width in bits.
REQ-003 Parameter DATA_WIDTH, default 70, gives the entry width in bits.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port din, input, DATA_WIDTH: write data.
REQ-007 Port wr_en, input, 1: write request.
REQ-008 Port rd_en, input, 1: read request.
REQ-009 Port dout, output, DATA_WIDTH: read data, registered.
REQ-010 Port rok, output, 1: read OK, meaning the FIFO is non-empty.
REQ-011 Port ack, output, 1: write acknowledge, meaning the FIFO is not full.

Function
REQ-012 Storage SHALL be FIFO_DEPTH entries of DATA_WIDTH bits, with a write pointer, a read pointer (FIFO_WIDTH bits each, wrapping modulo FIFO_DEPTH) and an occupancy count (FIFO_WIDTH+1 bits, range 0..FIFO_DEPTH).
REQ-013 Write: when wr_en=1 and count<FIFO_DEPTH, din SHALL be stored at the write pointer, and the write pointer SHALL increment at the clock edge.
REQ-014 Write when full (count=FIFO_DEPTH): din SHALL be dropped, and the pointers and count SHALL be unchanged.
REQ-015 Read: when rd_en=1 and count>0, dout SHALL load the entry at the read pointer at the clock edge (one-cycle latency), and the read pointer SHALL increment.
REQ-016 Read when empty: dout SHALL hold its previous value, and the pointers and count SHALL be unchanged.
REQ-017 Simultaneous accepted read and write SHALL leave count unchanged; an accepted write alone increments count, and an accepted read alone decrements it.
REQ-018 Full/empty checks SHALL use the pre-edge count.
  - When full, a write is refused even if a read occurs in the same cycle.
  - When empty, a read is ignored even if a write occurs in the same cycle.
REQ-019 rok SHALL be 1 exactly when count>0; ack SHALL be 1 exactly when count<FIFO_DEPTH. Both are combinational decodes of the registered count.
REQ-020 Data SHALL leave in the order written, with no reordering, duplication or loss of accepted entries across pointer wrap-around.
REQ-021 A written entry SHALL become visible on rok in the cycle after the write edge.

Reset
REQ-022 While rst=0, the pointers and count SHALL be 0 and dout SHALL be all-zero, taking effect immediately (asynchronously).
REQ-023 Therefore during and just after reset, rok=0 and ack=1.
REQ-024 Memory contents need not be reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries.
REQ-026 After rst deasserts, the first clock edge SHALL be able to accept a write.

Structure
REQ-027 No shared package is required; all sizing comes from the three parameters.
REQ-028 The block is a single module, with the storage array inferred inline; no sub-module.
REQ-029 Pointer and count logic SHALL be parameter-generic, with no hard-coded depth of 16.

Verification
REQ-030 Reset then idle -> rok=0, ack=1, dout=0.
REQ-031 Write 3 words (0x1, 0x2, 0x3), then read 3 -> dout shows 0x1, 0x2, 0x3 on successive cycles, each one cycle after its rd_en; rok=0 after the third read.
REQ-032 Write 17 words (0..16) with no reads -> ack=0 after the 16th; word 16 is dropped; reading 16 returns 0..15.
REQ-033 Read when empty with dout=0x3 -> dout stays 0x3 and rok stays 0.
REQ-034 Fill to 8, then wr_en=rd_en=1 for 20 cycles with an incrementing din -> count stays 8, and the output sequence is continuous across pointer wrap.
REQ-035 Fill to 5, then assert rst=0 mid-stream -> rok=0 and ack=1 immediately; a subsequent read returns only data written after reset.

Source files
------------

// File: rtl/input_buffer_first_pkg.sv
// Shared types for the input_buffer_first FIFO: per-cycle operation decode.
package input_buffer_first_pkg;

  typedef enum logic [1:0] {
    OpNone,
    OpWrite,
    OpRead,
    OpBoth
  } fifo_op_e;

  // Callers pass accepted requests, already qualified by full/empty.
  function automatic fifo_op_e decode_op(input logic wr_ok, input logic rd_ok);
    fifo_op_e op;
    unique case ({wr_ok, rd_ok})
      2'b10:   op = OpWrite;
      2'b01:   op = OpRead;
      2'b11:   op = OpBoth;
      default: op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/input_buffer_first.sv
// Synchronous FIFO with registered read data; rok flags non-empty and ack flags
// not-full, both decoded from the registered occupancy count.
module input_buffer_first
  import input_buffer_first_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 70
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rok,
  output logic                  ack
);

  localparam logic [FIFO_WIDTH:0]   CountFull = (FIFO_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH-1:0] PtrOne    = FIFO_WIDTH'(1);
  localparam logic [FIFO_WIDTH:0]   CountOne  = (FIFO_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic     wr_ok;
  logic     rd_ok;
  fifo_op_e op;

  // Full/empty use the pre-edge count, so a read never frees space for a
  // same-cycle write and a write never feeds a same-cycle read.
  assign rok   = (count_q != '0);
  assign ack   = (count_q != CountFull);
  assign wr_ok = wr_en & ack;
  assign rd_ok = rd_en & rok;
  assign op    = decode_op(wr_ok, rd_ok);
  assign dout  = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    unique case (op)
      OpWrite: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        count_d  = count_q + CountOne;
      end
      OpRead: begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        count_d  = count_q - CountOne;
        dout_d   = mem_q[rd_ptr_q];
      end
      OpBoth: begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        rd_ptr_d = rd_ptr_q + PtrOne;
        dout_d   = mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_input_buffer_first.sv
// Scoreboard bench for input_buffer_first: stimulus queues expected read data,
// a monitor compares dout one cycle after each accepted read.
module tb_input_buffer_first;

  localparam int DW    = 70;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          rok;
  logic          ack;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_accept = 1'b0;

  input_buffer_first #(
    .FIFO_DEPTH(DEPTH),
    .FIFO_WIDTH(4),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .dout (dout),
    .rok  (rok),
    .ack  (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: dout carries the next expected word one cycle after an accepted read.
  always @(posedge clk) begin
    if (rd_accept) begin
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dout_order: got %0h expected none at %0t", dout, $time);
      end else begin
        check("dout_order", dout, exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    logic wa;
    logic ra;
    wa = w && (model_q.size() < DEPTH);
    ra = r && (model_q.size() > 0);
    wr_en     = w;
    rd_en     = r;
    din       = d;
    rd_accept = ra;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_accept = 1'b0;
    check("rok", DW'(rok), DW'(model_q.size() > 0));
    check("ack", DW'(ack), DW'(model_q.size() < DEPTH));
  endtask

  initial begin
    rst   = 1'b0;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #12;
    check("reset_rok", DW'(rok), '0);
    check("reset_ack", DW'(ack), DW'(1));
    check("reset_dout", dout, '0);
    @(negedge clk);
    rst = 1'b1;

    // Three writes then three reads; first edge after reset accepts a write.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);
    check("drained_rok", DW'(rok), '0);

    // Read while empty holds dout.
    check("dout_before_empty_read", dout, DW'(3));
    cycle(1'b0, 1'b1, '0);
    check("empty_read_hold", dout, DW'(3));

    // Overfill: word 16 is dropped.
    for (int i = 0; i <= 16; i++) cycle(1'b1, 1'b0, DW'(i));
    check("full_ack", DW'(ack), '0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
    check("after_full_drain_rok", DW'(rok), '0);

    // Steady-state streaming at occupancy 8 across pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(100 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DW'(200 + i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);

    // Asynchronous reset mid-stream discards stored entries.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(300 + i));
    #2;
    rst = 1'b0;
    #1;
    check("midrst_rok", DW'(rok), '0);
    check("midrst_ack", DW'(ack), DW'(1));
    check("midrst_dout", dout, '0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b0, DW'('hA));
    cycle(1'b1, 1'b0, DW'('hB));
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    check("scoreboard_empty", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
